serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Bit-serial unsigned adder: the addition counterpart of the team's half-subtractor datapath.
//   Latches two WIDTH-bit operands on a start pulse and adds them LSB-first, one bit per clock.
//   Each bit uses a full-adder cell (two half-adder cells) plus a registered carry.
//   Presents sum and carry-out with a one-cycle done pulse. Used where area matters more than latency.
// PARAMETERS
//   WIDTH  8  operand/sum width in bits; legal range 2..32
// PORTS
//   clk    in   1      single clock; all state updates on posedge clk
//   rst    in   1      reset; synchronous, active-high
//   start  in   1      request; sampled only when FSM in IDLE or DONE
//   a      in   WIDTH  operand A; captured on the accepted start cycle
//   b      in   WIDTH  operand B; captured on the accepted start cycle
//   busy   out  1      high while FSM in RUN
//   done   out  1      one-cycle pulse; sum/cout valid from this cycle
//   sum    out  WIDTH  (a+b) mod 2^WIDTH; held until the next accepted start
//   cout   out  1      carry out of bit WIDTH-1; held with sum
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE; busy=0, done=0, sum=0, cout=0.
//     Shift registers, carry and bit counter cleared. Reset overrides start and aborts RUN.
//   FSM states and transitions:
//     IDLE: start=1 -> RUN. Load a_sh<=a, b_sh<=b; carry<=0; cnt<=0; sum<=0.
//     RUN (WIDTH cycles): compute s=a_sh[0]^b_sh[0]^carry and c=maj(a_sh[0],b_sh[0],carry).
//       Update sum<={s,sum[WIDTH-1:1]}, a_sh>>=1, b_sh>>=1, carry<=c, cnt<=cnt+1.
//       When cnt==WIDTH-1 -> DONE, with cout<=c.
//     DONE (1 cycle): done=1. start=1 -> RUN (same load as IDLE); otherwise -> IDLE.
//   Latency: start accepted at edge 0 -> busy=1 for edges 1..WIDTH -> done=1 in the cycle after edge WIDTH.
//     Throughput is one add per WIDTH+1 cycles with back-to-back starts.
//   start while busy=1 is ignored: no reload, no error flag, and the operation in flight is unaffected.
//   a and b may change freely after the accept cycle.
//   cnt is $clog2(WIDTH+1) bits wide and never wraps; it resets to 0 at each load.
//   sum and cout remain stable in IDLE after done. They change only on load (sum cleared) or in RUN.
// CONFIGURATION
//   SERIAL_ADDER_OVF_EN defined: adds output port ovf (out, 1).
//     ovf = signed two's-complement overflow = carry-into MSB ^ carry-out MSB.
//     Registered with cout, reset to 0, held with sum.
//   SERIAL_ADDER_OVF_EN undefined: no ovf port, no extra logic; all other behaviour identical.
// STRUCTURE
//   Shared package serial_adder_pkg: FSM state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//     Encoding 2'd3 is illegal and decodes to IDLE.
//   Sub-module serial_fa_cell (a, b, cin -> s, cout): combinational full adder from two half-adder
//     instances (XOR/AND) plus an OR gate. Instantiated once; all state lives in serial_adder.
// TESTING (WIDTH=8)
//   a=8'h00, b=8'h00, start at cycle 0 -> busy cycles 1-8; done at cycle 9; sum=8'h00, cout=0.
//   a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. a=8'h5A, b=8'h3C -> sum=8'h96, cout=0.
//   Start 8'h0F+8'h01, then pulse start with 8'hFF+8'hFF at cycle 3 -> ignored; result sum=8'h10, cout=0.
//   rst=1 at cycle 4 mid-RUN -> next cycle busy=0, done=0, sum=0, cout=0, IDLE; no done pulse follows.
//   start held high on the DONE cycle with a=8'h80, b=8'h80 -> busy next cycle; done 9 cycles later;
//     sum=8'h00, cout=1; previous sum stays visible during the DONE cycle.
//   With SERIAL_ADDER_OVF_EN: 8'h7F+8'h01 -> sum=8'h80, ovf=1, cout=0. 8'hFF+8'h01 -> ovf=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module : serial_adder_pkg
// Brief  : Shared FSM state encoding for the bit-serial adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  // Encoding 2'd3 is unused; the FSM decodes it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/serial_fa_cell.sv
// ============================================================================
// Module : serial_fa_cell
// Brief  : Combinational full adder built from two half-adder cells and an OR.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  serial_ha_cell u_ha0 (
    .i_a (a),
    .i_b (b),
    .o_s (w_s1),
    .o_c (w_c1)
  );

  serial_ha_cell u_ha1 (
    .i_a (w_s1),
    .i_b (cin),
    .o_s (s),
    .o_c (w_c2)
  );

  // At most one of the two half-adder carries can be set, so OR gives the majority.
  assign cout = w_c1 | w_c2;

endmodule : serial_fa_cell

`default_nettype wire

// File: rtl/serial_ha_cell.sv
// ============================================================================
// Module : serial_ha_cell
// Brief  : Combinational half adder (XOR sum, AND carry).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_ha_cell (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule : serial_ha_cell

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module : serial_adder
// Brief  : Bit-serial unsigned adder, LSB first, one bit per clock.
//          Optional macro SERIAL_ADDER_OVF_EN adds a signed-overflow output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic               w_last;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_s;
  logic               w_c;

  // One shared full-adder cell processes the current LSBs with the stored carry.
  serial_fa_cell u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode; start is only honoured outside RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      default: begin
        // IDLE, DONE and the unused encoding all accept a new start.
        if (start) begin
          w_state_nxt = ST_RUN;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // Operand shifters, carry chain, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_carry <= w_c;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) r_cout <= w_c;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst)                              r_ovf <= 1'b0;
    else if ((r_state == ST_RUN) && w_last) r_ovf <= r_carry ^ w_c;
  end

  assign ovf = r_ovf;
`endif

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule : serial_adder

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module : tb_serial_adder
// Brief  : Directed self-checking bench for serial_adder (WIDTH=8) with a
//          result scoreboard. Honours SERIAL_ADDER_OVF_EN when defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one start cycle; optionally record the expected result.
  task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb, input bit push);
    logic [W:0] full;
    exp_t       e;
    full   = {1'b0, va} + {1'b0, vb};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (va[W-1] == vb[W-1]) && (full[W-1] != va[W-1]);
    start  = 1'b1;
    a      = va;
    b      = vb;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    start  = 1'b0;
    a      = W'($urandom);
    b      = W'($urandom);
  endtask

  // Wait (bounded) for done, count busy cycles, then compare against the scoreboard.
  task automatic wait_done(input string tag, input int exp_busy);
    int   n_busy;
    bit   seen;
    exp_t e;
    n_busy = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done)      seen = 1'b1;
      else if (busy) n_busy++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_busy_cycles"}, 32'(n_busy), 32'(exp_busy));
      chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_sum"},  32'(sum),  32'(e.sum));
        chk({tag, "_cout"}, 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"},  32'(ovf),  32'(e.ovf));
`endif
      end
    end
  endtask

  // After a done pulse: done drops and the result is held in IDLE.
  task automatic chk_hold(input string tag, input logic [W-1:0] exp_sum, input logic exp_cout);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold_sum"},   32'(sum),  32'(exp_sum));
    chk({tag, "_hold_cout"},  32'(cout), 32'(exp_cout));
  endtask

  initial begin
    int n_done;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf",  32'(ovf),  32'd0);
`endif

    // Zero operands: 8 busy cycles then done.
    @(posedge clk); #1;
    start_op(8'h00, 8'h00, 1'b1);
    wait_done("zero", 8);
    chk_hold("zero", 8'h00, 1'b0);

    // Mixed pattern, no carry out.
    @(posedge clk); #1;
    start_op(8'h5A, 8'h3C, 1'b1);
    wait_done("5a3c", 8);
    chk_hold("5a3c", 8'h96, 1'b0);

    // Start pulse while busy must be ignored.
    @(posedge clk); #1;
    start_op(8'h0F, 8'h01, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore", 4);
    chk_hold("ignore", 8'h10, 1'b0);

    // Full wrap: carry out set.
    @(posedge clk); #1;
    start_op(8'hFF, 8'h01, 1'b1);
    wait_done("wrap", 8);
    chk_hold("wrap", 8'h00, 1'b1);

    // Reset mid-RUN aborts the operation with no done pulse.
    @(posedge clk); #1;
    start_op(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_pre_busy", 32'(busy), 32'd1);
    chk("midrst_pre_cout", 32'(cout), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum",  32'(sum),  32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("midrst_no_done", 32'(n_done), 32'd0);

    // Back-to-back: start held on the DONE cycle.
    @(posedge clk); #1;
    start_op(8'h11, 8'h22, 1'b1);
    wait_done("b2b_first", 8);
    start_op(8'h80, 8'h80, 1'b1);
    chk("b2b_prev_sum_seen", 32'(sum), 32'h00);
    @(negedge clk);
    chk("b2b_busy_next", 32'(busy), 32'd1);
    wait_done("b2b_second", 7);
    chk_hold("b2b_second", 8'h00, 1'b1);

`ifdef SERIAL_ADDER_OVF_EN
    // Signed overflow cases.
    @(posedge clk); #1;
    start_op(8'h7F, 8'h01, 1'b1);
    wait_done("ovf_pos", 8);
    @(posedge clk); #1;
    start_op(8'hFF, 8'h01, 1'b1);
    wait_done("ovf_none", 8);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_adder

`default_nettype wire
